debounce_ctrl: RTL and testbench

DEBOUNCE_CTRL -- requirements
Module: debounce_ctrl

---
 rtl/debounce_ctrl.sv | 101 ++++++++++
 tb/tb_debounce_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/debounce_ctrl.sv
// debounce_ctrl: per-channel switch debouncer qualified by a shared 10 ms tick.
//   Each sw bit passes a 2-flop synchronizer, then a ZERO/WAIT1/ONE/WAIT0 FSM
//   accepts a new level only after it survives STABLE_TICKS consecutive ticks.
//   Optional macro DEBOUNCE_CTRL_EDGE_EN enables registered db_rise/db_fall pulses;
//   without it both ports are tied to 0.
//   Ports: clk, reset (async, active-high), ms10_tick (1-cycle strobe),
//          sw[W] raw levels, db_level[W] debounced level,
//          db_rise[W]/db_fall[W] one-cycle edge pulses.
module debounce_ctrl #(
  parameter int W = 4,
  parameter int STABLE_TICKS = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ms10_tick,
  input  logic [W-1:0] sw,
  output logic [W-1:0] db_level,
  output logic [W-1:0] db_rise,
  output logic [W-1:0] db_fall
);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);
  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;
  logic [W-1:0] sync1_q, sw_s_q, level_d, level_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync1_q <= '0;
      sw_s_q  <= '0;
      level_q <= '0;
    end else begin
      sync1_q <= sw;
      sw_s_q  <= sync1_q;
      level_q <= level_d;
    end
  assign db_level = level_q;
  for (genvar i = 0; i < W; i++) begin : g_ch
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        state_q <= ZERO;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    // Reversion is tested before the tick so a bounce coinciding with the
    // qualifying tick cancels the transition.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        ZERO:  if (sw_s_q[i]) begin
                 state_d = WAIT1;
                 cnt_d   = '0;
               end
        WAIT1: if (!sw_s_q[i]) begin
                 state_d = ZERO;
                 cnt_d   = '0;
               end else if (ms10_tick) begin
                 state_d = (cnt_q == LAST) ? ONE : WAIT1;
                 cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
               end
        ONE:   if (!sw_s_q[i]) begin
                 state_d = WAIT0;
                 cnt_d   = '0;
               end
        WAIT0: if (sw_s_q[i]) begin
                 state_d = ONE;
                 cnt_d   = '0;
               end else if (ms10_tick) begin
                 state_d = (cnt_q == LAST) ? ZERO : WAIT0;
                 cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
               end
      endcase
    end
    assign level_d[i] = (state_q == ONE) || (state_q == WAIT0);
  end
`ifdef DEBOUNCE_CTRL_EDGE_EN
  // Pulses are registered alongside level_q so they coincide with the first
  // cycle db_level shows the new value.
  logic [W-1:0] rise_d, rise_q, fall_d, fall_q;
  always_comb begin
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  assign db_rise = rise_q;
  assign db_fall = fall_q;
`else
  assign db_rise = '0;
  assign db_fall = '0;
`endif
endmodule

// File: tb/tb_debounce_ctrl.sv
// tb_debounce_ctrl: scoreboard bench for debounce_ctrl (W=4, STABLE_TICKS=3, tick every 8 cycles).
module tb_debounce_ctrl;
  localparam int W = 4;
  logic clk = 1'b0, reset = 1'b1, ms10_tick = 1'b0;
  logic [W-1:0] sw = '0;
  logic [W-1:0] db_level, db_rise, db_fall;
  int cyc = 0, checks = 0, fails = 0;
  typedef struct {
    logic [W-1:0] lvl;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    int at;
  } ev_t;
  ev_t exp_q[$];
  logic [W-1:0] prev_lvl = '0;

  debounce_ctrl #(.W(W), .STABLE_TICKS(3)) dut (
    .clk(clk), .reset(reset), .ms10_tick(ms10_tick), .sw(sw),
    .db_level(db_level), .db_rise(db_rise), .db_fall(db_fall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Ticks are sampled at posedges whose count is a multiple of 8.
  always @(negedge clk) ms10_tick = (cyc % 8 == 7);

  // sw first sampled at posedge k: FSM sees it at k+2, counting ticks start
  // at the first multiple of 8 >= k+3, the third tick moves the FSM, and the
  // output register shows it one cycle later.
  function automatic int ev_cyc(int k);
    return ((k + 10) / 8) * 8 + 17;
  endfunction

  task automatic push(logic [W-1:0] lvl, logic [W-1:0] edges, bit up, int k);
    ev_t e;
    e.lvl  = lvl;
    e.rise = '0;
    e.fall = '0;
`ifdef DEBOUNCE_CTRL_EDGE_EN
    if (up) e.rise = edges;
    else e.fall = edges;
`endif
    e.at = ev_cyc(k);
    exp_q.push_back(e);
  endtask

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drive(logic [W-1:0] v, output int k);
    @(negedge clk);
    sw = v;
    k = cyc + 1;
  endtask

  always @(negedge clk) begin
    if (reset) prev_lvl = '0;
    else if (db_level !== prev_lvl || (db_rise | db_fall) !== '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: cyc=%0d level=%b rise=%b fall=%b, expected no event",
                 cyc, db_level, db_rise, db_fall);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if ({db_level, db_rise, db_fall} !== {e.lvl, e.rise, e.fall} || cyc != e.at) begin
          fails++;
          $display("FAIL event: cyc=%0d level=%b rise=%b fall=%b, expected cyc=%0d level=%b rise=%b fall=%b",
                   cyc, db_level, db_rise, db_fall, e.at, e.lvl, e.rise, e.fall);
        end
      end
      prev_lvl = db_level;
    end
  end

  initial begin
    int k, t1, t3;
    repeat (3) @(negedge clk);
    check("reset_level", db_level, '0);
    check("reset_rise", db_rise, '0);
    check("reset_fall", db_fall, '0);
    reset = 1'b0;
    // single channel rise then fall
    drive(4'b0001, k);
    push(4'b0001, 4'b0001, 1'b1, k);
    wait_to(ev_cyc(k) + 6);
    drive(4'b0000, k);
    push(4'b0000, 4'b0001, 1'b0, k);
    wait_to(ev_cyc(k) + 6);
    // 10-cycle glitch never qualifies
    drive(4'b0010, k);
    repeat (10) @(negedge clk);
    sw = '0;
    wait_to(k + 40);
    check("glitch_level", db_level, '0);
    // reversion seen in the same cycle as the third tick wins
    drive(4'b0100, k);
    t3 = ev_cyc(k) - 1;
    wait_to(t3 - 3);
    sw = '0;
    wait_to(t3 + 30);
    check("revert_level", db_level, '0);
    // all channels together
    drive(4'b1111, k);
    push(4'b1111, 4'b1111, 1'b1, k);
    wait_to(ev_cyc(k) + 6);
    drive(4'b0000, k);
    push(4'b0000, 4'b1111, 1'b0, k);
    wait_to(ev_cyc(k) + 6);
    // reset after two qualifying ticks discards the count
    drive(4'b1000, k);
    t1 = ((k + 10) / 8) * 8;
    wait_to(t1 + 10);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_level", db_level, '0);
    check("midreset_rise", db_rise, '0);
    check("midreset_fall", db_fall, '0);
    @(negedge clk);
    reset = 1'b0;
    k = cyc + 1;
    push(4'b1000, 4'b1000, 1'b1, k);
    wait_to(ev_cyc(k) + 6);
    drive(4'b0000, k);
    push(4'b0000, 4'b1000, 1'b0, k);
    wait_to(ev_cyc(k) + 6);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d events outstanding, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
